// File: rtl/fetch_inst_buffer.sv
// Circular instruction queue between FetchStage2 and Decode: up to FETCH_W pushes and DECODE_W pops per cycle.
// Optional same-cycle bypass when empty is enabled by defining FETCH_BUF_BYPASS_EN.
module fetch_inst_buffer #(
   parameter int PKT_W    = 133,
   parameter int DEPTH    = 16,
   parameter int FETCH_W  = 4,
   parameter int DECODE_W = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        flush_i,
   input  logic                        fs2Ready_i,
   input  logic [FETCH_W-1:0]          instValid_i,
   input  logic [FETCH_W*PKT_W-1:0]    instPacket_i,
   input  logic                        decodeReady_i,
   output logic [DECODE_W-1:0]         instValid_o,
   output logic [DECODE_W*PKT_W-1:0]   instPacket_o,
   output logic                        bufferStall_o,
   output logic [$clog2(DEPTH):0]      count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [PKT_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]    head_q, head_d;
   logic [AW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic [CW-1:0]    wr_n, rd_n, wr_eff;
   logic             push_en, wr_en;
   logic [AW-1:0]    wr_idx [FETCH_W];
   logic [AW-1:0]    rd_idx [DECODE_W];

   // Stall looks only at current occupancy; a same-cycle pop is deliberately not credited.
   assign bufferStall_o = (count_q > CW'(DEPTH - FETCH_W));
   assign push_en       = fs2Ready_i & ~bufferStall_o & ~flush_i;
   assign count_o       = count_q;

`ifdef FETCH_BUF_BYPASS_EN
   logic bypass;
   assign bypass = push_en & (count_q == '0);
   // Bypassed packets that Decode accepts this cycle never enter storage.
   assign wr_en  = push_en & ~(bypass & decodeReady_i);
`else
   assign wr_en  = push_en;
`endif

   always_comb begin
      wr_n = '0;
      for (int k = 0; k < FETCH_W; k++) begin
         wr_n = wr_n + CW'(instValid_i[k]);
      end
      rd_n = '0;
      if (decodeReady_i) begin
         rd_n = (count_q >= CW'(DECODE_W)) ? CW'(DECODE_W) : count_q;
      end
      wr_eff = wr_en ? wr_n : '0;
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + rd_n[AW-1:0];
         tail_d  = tail_q + wr_eff[AW-1:0];
         count_d = count_q + wr_eff - rd_n;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   generate
      for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_wr
         assign wr_idx[gi] = tail_q + AW'(gi);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int k = 0; k < FETCH_W; k++) begin
            if (CW'(k) < wr_n) begin
               mem_q[wr_idx[k]] <= instPacket_i[k*PKT_W +: PKT_W];
            end
         end
      end
   end

   // Valids derive from count only, so uninitialised storage never leaks X into them.
   generate
      for (genvar gi = 0; gi < DECODE_W; gi++) begin : g_rd
         logic slot_valid;
         assign rd_idx[gi] = head_q + AW'(gi);
         assign slot_valid = (CW'(gi) < count_q);
`ifdef FETCH_BUF_BYPASS_EN
         if (gi < FETCH_W) begin : g_byp
            assign instValid_o[gi] = bypass ? instValid_i[gi] : slot_valid;
            assign instPacket_o[gi*PKT_W +: PKT_W] =
               bypass ? instPacket_i[gi*PKT_W +: PKT_W] : mem_q[rd_idx[gi]];
         end else begin : g_nobyp
            assign instValid_o[gi] = ~bypass & slot_valid;
            assign instPacket_o[gi*PKT_W +: PKT_W] = mem_q[rd_idx[gi]];
         end
`else
         assign instValid_o[gi] = slot_valid;
         assign instPacket_o[gi*PKT_W +: PKT_W] = mem_q[rd_idx[gi]];
`endif
      end
   endgenerate

   a_prefix: assert property (@(posedge clk) disable iff (reset)
      push_en |-> ((instValid_i & (instValid_i + FETCH_W'(1))) == '0));

endmodule
